// File: rtl/shift_rows_pipe.sv
// Rijndael ShiftRows / InvShiftRows for 4, 6 or 8 columns, followed by an elastic
// valid/ready register pipeline that carries a sideband tag with each state.
module shift_rows_pipe #(
  parameter int NB          = 4,
  parameter int PIPE_STAGES = 1,
  parameter int TAG_W       = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_inv,
  input  logic [TAG_W-1:0]    in_tag,
  input  logic [32*NB-1:0]    state_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [TAG_W-1:0]    out_tag,
  output logic [32*NB-1:0]    state_out,
  output logic                busy
);

  localparam int W = 32 * NB;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_stages
    $error("shift_rows_pipe: PIPE_STAGES must be 1..4");
  end
  if (TAG_W < 1 || TAG_W > 16) begin : g_bad_tag
    $error("shift_rows_pipe: TAG_W must be 1..16");
  end

  logic [W-1:0] fwd_perm;
  logic [W-1:0] inv_perm;
  logic [W-1:0] perm;

  // Byte k sits at state_in[W-1-8k -: 8]; byte 4c+r is row r of column c.
  for (genvar gi = 0; gi < NB; gi++) begin : g_col
    for (genvar gr = 0; gr < 4; gr++) begin : g_row
      localparam int OFF = (NB == 8 && gr >= 2) ? gr + 1 : gr;
      localparam int FSRC = (gi + OFF) % NB;
      localparam int ISRC = (gi - OFF + NB) % NB;
      assign fwd_perm[W-1-8*(4*gi+gr) -: 8] = state_in[W-1-8*(4*FSRC+gr) -: 8];
      assign inv_perm[W-1-8*(4*gi+gr) -: 8] = state_in[W-1-8*(4*ISRC+gr) -: 8];
    end
  end

  assign perm = in_inv ? inv_perm : fwd_perm;

  logic [PIPE_STAGES-1:0] valid_reg;
  logic [W-1:0]           data_reg [PIPE_STAGES];
  logic [TAG_W-1:0]       tag_reg  [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] stage_ready;

  // A stage can take data when any stage at or after it has a hole, or the
  // output drains this cycle; evaluated flat so there is no combinational chain.
  always_comb begin
    stage_ready = '0;
    for (int k = 0; k < PIPE_STAGES; k++) begin
      stage_ready[k] = out_ready;
      for (int j = k; j < PIPE_STAGES; j++) begin
        if (!valid_reg[j]) begin
          stage_ready[k] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
      for (int i = 0; i < PIPE_STAGES; i++) begin
        data_reg[i] <= '0;
        tag_reg[i]  <= '0;
      end
    end else begin
      if (stage_ready[0]) begin
        valid_reg[0] <= in_valid;
        if (in_valid) begin
          data_reg[0] <= perm;
          tag_reg[0]  <= in_tag;
        end
      end
      for (int i = 1; i < PIPE_STAGES; i++) begin
        if (stage_ready[i]) begin
          valid_reg[i] <= valid_reg[i-1];
          if (valid_reg[i-1]) begin
            data_reg[i] <= data_reg[i-1];
            tag_reg[i]  <= tag_reg[i-1];
          end
        end
      end
    end
  end

  assign in_ready  = stage_ready[0] && !rst;
  assign out_valid = valid_reg[PIPE_STAGES-1];
  assign state_out = data_reg[PIPE_STAGES-1];
  assign out_tag   = tag_reg[PIPE_STAGES-1];
  assign busy      = |valid_reg;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Scoreboard bench: two instances (NB=4/3 stages, NB=8/1 stage); drivers queue the
// expected results and per-instance monitors pop and compare on each output transfer.
module tb_shift_rows_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic         in_valid_a, in_ready_a, in_inv_a, out_valid_a, out_ready_a, busy_a;
  logic [3:0]   in_tag_a, out_tag_a;
  logic [127:0] state_in_a, state_out_a;

  logic         in_valid_b, in_ready_b, in_inv_b, out_valid_b, out_ready_b, busy_b;
  logic [3:0]   in_tag_b, out_tag_b;
  logic [255:0] state_in_b, state_out_b;

  shift_rows_pipe #(.NB(4), .PIPE_STAGES(3), .TAG_W(4)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_inv(in_inv_a),
    .in_tag(in_tag_a), .state_in(state_in_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_tag(out_tag_a),
    .state_out(state_out_a), .busy(busy_a)
  );

  shift_rows_pipe #(.NB(8), .PIPE_STAGES(1), .TAG_W(4)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_inv(in_inv_b),
    .in_tag(in_tag_b), .state_in(state_in_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_tag(out_tag_b),
    .state_out(state_out_b), .busy(busy_b)
  );

  localparam logic [127:0] V4 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] F4 = 128'h00050A0F04090E03080D02070C01060B;
  localparam logic [127:0] I4 = 128'h000D0A0704010E0B0805020F0C090603;
  localparam logic [255:0] V8 =
    256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;
  localparam logic [255:0] F8 =
    256'h00050E13040912170_80D161B0C111A1F10151E0314190207181D060B1C010A0F >> 0;

  typedef struct {
    logic [255:0] data;
    logic [3:0]   tag;
    int           issue;
    bit           chk_lat;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   rand_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] ref4(input logic inv, input logic [127:0] s);
    logic [127:0] b;
    int src;
    b = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c - r + 4) % 4 : (c + r) % 4;
        b[127-8*(4*c+r) -: 8] = s[127-8*(4*src+r) -: 8];
      end
    end
    return b;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid_a && out_ready_a) begin
      if (q_a.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL a_unexpected_output actual_tag=%h required=none", out_tag_a);
      end else begin
        ea = q_a.pop_front();
        $display("a out tag=%h data=%h", out_tag_a, state_out_a);
        check("a_data", {128'b0, state_out_a}, ea.data);
        check("a_tag", {252'b0, out_tag_a}, {252'b0, ea.tag});
        if (ea.chk_lat) check("a_latency", cyc - ea.issue, 3);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid_b && out_ready_b) begin
      if (q_b.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_unexpected_output actual_tag=%h required=none", out_tag_b);
      end else begin
        eb = q_b.pop_front();
        $display("b out tag=%h data=%h", out_tag_b, state_out_b);
        check("b_data", state_out_b, eb.data);
        check("b_tag", {252'b0, out_tag_b}, {252'b0, eb.tag});
        if (eb.chk_lat) check("b_latency", cyc - eb.issue, 1);
      end
    end
  end

  always @(posedge clk) begin
    if (rand_en) begin
      #1 out_ready_a = 1'($urandom_range(0, 1));
    end
  end

  // Present one transaction; waited reports how many cycles in_ready stayed low.
  task automatic push_a(input logic inv, input logic [3:0] tag, input logic [127:0] d,
                        input logic [127:0] exp, input bit lat, output int waited);
    in_valid_a = 1'b1;
    in_inv_a   = inv;
    in_tag_a   = tag;
    state_in_a = d;
    waited     = 0;
    forever begin
      @(negedge clk);
      if (in_ready_a) break;
      waited++;
      if (waited > 200) break;
    end
    if (waited > 200) begin
      checks++;
      failures++;
      $display("FAIL a_push_timeout actual=in_ready_low required=accept tag=%h", tag);
    end else begin
      q_a.push_back('{data: {128'b0, exp}, tag: tag, issue: cyc, chk_lat: lat});
      $display("a in  tag=%h inv=%0d data=%h", tag, inv, d);
    end
    @(posedge clk);
    #1 in_valid_a = 1'b0;
  endtask

  task automatic push_b(input logic inv, input logic [3:0] tag, input logic [255:0] d,
                        input logic [255:0] exp);
    int waited;
    in_valid_b = 1'b1;
    in_inv_b   = inv;
    in_tag_b   = tag;
    state_in_b = d;
    waited     = 0;
    forever begin
      @(negedge clk);
      if (in_ready_b) break;
      waited++;
      if (waited > 200) break;
    end
    if (waited > 200) begin
      checks++;
      failures++;
      $display("FAIL b_push_timeout actual=in_ready_low required=accept tag=%h", tag);
    end else begin
      q_b.push_back('{data: exp, tag: tag, issue: cyc, chk_lat: 1'b1});
      $display("b in  tag=%h inv=%0d data=%h", tag, inv, d);
    end
    @(posedge clk);
    #1 in_valid_b = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      failures++;
      $display("FAIL %s actual_pending=%0d required=0", name, q_a.size() + q_b.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=no_finish required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    logic [127:0] d;
    logic inv;
    rst = 1'b1;
    in_valid_a = 0; in_inv_a = 0; in_tag_a = 0; state_in_a = 0; out_ready_a = 1;
    in_valid_b = 0; in_inv_b = 0; in_tag_b = 0; state_in_b = 0; out_ready_b = 1;
    repeat (2) @(negedge clk);
    check("rst_in_ready_forced_low", {255'b0, in_ready_a}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", {255'b0, out_valid_a}, 0);
    check("reset_busy", {255'b0, busy_a}, 0);
    check("reset_in_ready", {255'b0, in_ready_a}, 1);
    check("reset_state_out", {128'b0, state_out_a}, 0);
    check("reset_out_tag", {252'b0, out_tag_a}, 0);
    check("reset_b_out_valid", {255'b0, out_valid_b}, 0);
    @(posedge clk);
    #1;

    // NB=8: forward, then inverse of the forward result restores the input
    push_b(1'b0, 4'h1, V8, F8);
    push_b(1'b1, 4'h2, F8, V8);
    wait_drain("b_drain");

    // NB=4 directed vectors through the 3-stage pipe
    push_a(1'b0, 4'h1, V4, F4, 1'b1, w);
    wait_drain("a_fwd_drain");
    push_a(1'b1, 4'h2, V4, I4, 1'b1, w);
    wait_drain("a_inv_drain");
    push_a(1'b1, 4'h3, F4, V4, 1'b1, w);
    wait_drain("a_roundtrip_drain");

    // Backpressure: fill the pipe, verify hold, then push during the first drain cycle
    out_ready_a = 1'b0;
    push_a(1'b0, 4'h1, V4, F4, 1'b0, w);
    push_a(1'b1, 4'h2, V4, I4, 1'b0, w);
    push_a(1'b1, 4'h3, F4, V4, 1'b0, w);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_in_ready", {255'b0, in_ready_a}, 0);
      check("full_busy", {255'b0, busy_a}, 1);
      check("stall_out_tag", {252'b0, out_tag_a}, 1);
      check("stall_state_out", {128'b0, state_out_a}, {128'b0, F4});
    end
    @(posedge clk);
    #1 out_ready_a = 1'b1;
    push_a(1'b0, 4'h4, I4, V4, 1'b0, w);
    check("simul_push_accepted_wait", w, 0);
    wait_drain("bp_drain");

    // Alternating directions with random downstream readiness
    rand_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      inv = 1'(i % 2);
      push_a(inv, 4'(i + 5), d, ref4(inv, d), 1'b0, w);
    end
    rand_en = 1'b0;
    @(posedge clk);
    #2 out_ready_a = 1'b1;
    wait_drain("alt_drain");

    // Reset with two transactions in flight
    out_ready_a = 1'b0;
    push_a(1'b0, 4'hA, V4, F4, 1'b0, w);
    push_a(1'b0, 4'hB, V4, F4, 1'b0, w);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    q_a.delete();
    out_ready_a = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", {255'b0, out_valid_a}, 0);
    check("midrst_busy", {255'b0, busy_a}, 0);
    check("midrst_in_ready", {255'b0, in_ready_a}, 1);
    check("midrst_out_tag", {252'b0, out_tag_a}, 0);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    push_a(1'b1, 4'hC, V4, I4, 1'b1, w);
    wait_drain("post_rst_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
